// File: rtl/dds_mod_sequencer.sv
// Symbol-rate sequencer for the DDS modulation selector: symbol timing, LFSR data bit,
// mode handshake applied on symbol boundaries. Optional auto mode cycling: DDS_SEQ_AUTO_CYCLE_EN.
module dds_mod_sequencer #(
  parameter int unsigned SYM_DIV   = 50_000_000,
  parameter logic [4:0]  LFSR_SEED = 5'b00001
`ifdef DDS_SEQ_AUTO_CYCLE_EN
  , parameter int unsigned AUTO_SYMS = 8
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] carrier_inc,
  input  logic [31:0] f0_inc,
  input  logic [31:0] f1_inc,
  input  logic [3:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  output logic        dds_en,
  output logic        lfsr_bit,
  output logic        sym_tick,
  output logic [3:0]  mod_sel,
  output logic [31:0] phase_inc,
  output logic [31:0] fsk_phase_inc,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(SYM_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYM_DIV - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       lfsr, lfsr_nxt;
  logic             pend, pend_nxt;
  logic [3:0]       pend_mode, pend_mode_nxt;
  logic [3:0]       mod_sel_nxt;
  logic             tick_nxt;
  logic             tc;
  logic             boundary;

`ifdef DDS_SEQ_AUTO_CYCLE_EN
  localparam int unsigned SYM_W = $clog2(AUTO_SYMS) + 1;
  logic [SYM_W-1:0] sym_cnt, sym_cnt_nxt;
`endif

  // Ready is simply "nothing pending"; pend is a flop so the output stays registered.
  assign mode_req_ready = ~pend;
  assign lfsr_bit       = lfsr[0];
  assign tc             = (cnt == CNT_MAX);
  assign boundary       = ((state == RUN) || (state == DRAIN)) && tc;

  // Next-state, counter, LFSR and mode handshake.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    lfsr_nxt      = lfsr;
    pend_nxt      = pend;
    pend_mode_nxt = pend_mode;
    mod_sel_nxt   = mod_sel;
    tick_nxt      = 1'b0;
`ifdef DDS_SEQ_AUTO_CYCLE_EN
    sym_cnt_nxt   = sym_cnt;
`endif

    case (state)
      IDLE: begin
        if (start && !stop) state_nxt = ARM;
      end
      ARM: begin
        lfsr_nxt  = LFSR_SEED;
        cnt_nxt   = '0;
        state_nxt = RUN;
`ifdef DDS_SEQ_AUTO_CYCLE_EN
        sym_cnt_nxt = '0;
`endif
      end
      RUN, DRAIN: begin
        cnt_nxt = tc ? '0 : cnt + CNT_W'(1);
        if (tc) begin
          tick_nxt = 1'b1;
          lfsr_nxt = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
        end
        // A stop seen on the terminal count already finishes the current symbol.
        if (state == RUN && stop) state_nxt = tc ? IDLE : DRAIN;
        if (state == DRAIN && tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

`ifdef DDS_SEQ_AUTO_CYCLE_EN
    if (state == RUN && tc) begin
      if (pend) begin
        sym_cnt_nxt = '0;
      end else if (sym_cnt == SYM_W'(AUTO_SYMS - 1)) begin
        sym_cnt_nxt = '0;
        mod_sel_nxt = (mod_sel >= 4'd3) ? 4'd0 : mod_sel + 4'd1;
      end else begin
        sym_cnt_nxt = sym_cnt + SYM_W'(1);
      end
    end
`endif

    if (pend && ((state == IDLE) || (state == ARM) || boundary)) begin
      mod_sel_nxt = pend_mode;
      pend_nxt    = 1'b0;
    end
    if (mode_req_valid && !pend) begin
      pend_nxt      = 1'b1;
      pend_mode_nxt = mode_req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lfsr          <= LFSR_SEED;
      pend          <= 1'b0;
      pend_mode     <= 4'd0;
      mod_sel       <= 4'd0;
      sym_tick      <= 1'b0;
      dds_en        <= 1'b0;
      busy          <= 1'b0;
      phase_inc     <= 32'd0;
      fsk_phase_inc <= 32'd0;
`ifdef DDS_SEQ_AUTO_CYCLE_EN
      sym_cnt       <= '0;
`endif
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      lfsr          <= lfsr_nxt;
      pend          <= pend_nxt;
      pend_mode     <= pend_mode_nxt;
      mod_sel       <= mod_sel_nxt;
      sym_tick      <= tick_nxt;
      dds_en        <= (state_nxt == RUN) || (state_nxt == DRAIN);
      busy          <= (state_nxt != IDLE);
      phase_inc     <= carrier_inc;
      // Built from the LFSR's next value so it changes together with lfsr_bit.
      fsk_phase_inc <= lfsr_nxt[0] ? f1_inc : f0_inc;
`ifdef DDS_SEQ_AUTO_CYCLE_EN
      sym_cnt       <= sym_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_dds_mod_sequencer.sv
// Scoreboard bench for dds_mod_sequencer (SYM_DIV=4): expected symbol-boundary records are
// queued by the stimulus and checked by a monitor on every sym_tick.
module tb_dds_mod_sequencer;

  localparam logic [31:0] CAR = 32'h1234_5678;
  localparam logic [31:0] F0  = 32'h0000_1000;
  localparam logic [31:0] F1  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop;
  logic [31:0] carrier_inc, f0_inc, f1_inc;
  logic [3:0]  mode_req;
  logic        mode_req_valid;
  logic        mode_req_ready, dds_en, lfsr_bit, sym_tick, busy;
  logic [3:0]  mod_sel;
  logic [31:0] phase_inc, fsk_phase_inc;

  typedef struct packed {
    logic       bit_v;
    logic [3:0] mode;
    logic       rdy;
    logic       en;
    logic       bsy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  dds_mod_sequencer #(.SYM_DIV(4), .LFSR_SEED(5'b00001)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .carrier_inc(carrier_inc), .f0_inc(f0_inc), .f1_inc(f1_inc),
    .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
    .dds_en(dds_en), .lfsr_bit(lfsr_bit), .sym_tick(sym_tick), .mod_sel(mod_sel),
    .phase_inc(phase_inc), .fsk_phase_inc(fsk_phase_inc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b, input logic [3:0] m, input logic r, input logic e, input logic bs);
    exp_t x;
    x.bit_v = b; x.mode = m; x.rdy = r; x.en = e; x.bsy = bs;
    exp_q.push_back(x);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".dds_en"},   32'(dds_en), 32'd0);
    chk({tag, ".lfsr_bit"}, 32'(lfsr_bit), 32'd1);
    chk({tag, ".sym_tick"}, 32'(sym_tick), 32'd0);
    chk({tag, ".mod_sel"},  32'(mod_sel), 32'd0);
    chk({tag, ".phase"},    phase_inc, 32'd0);
    chk({tag, ".fsk"},      fsk_phase_inc, 32'd0);
    chk({tag, ".busy"},     32'(busy), 32'd0);
    chk({tag, ".ready"},    32'(mode_req_ready), 32'd1);
  endtask

  // Monitor: each symbol boundary must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sym_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tick_unexpected: got sym_tick=1 at %0t, expected no boundary", $time);
        end else begin
          e = exp_q.pop_front();
          chk("tick.lfsr_bit", 32'(lfsr_bit), 32'(e.bit_v));
          chk("tick.fsk",      fsk_phase_inc, e.bit_v ? F1 : F0);
          chk("tick.mod_sel",  32'(mod_sel), 32'(e.mode));
          chk("tick.ready",    32'(mode_req_ready), 32'(e.rdy));
          chk("tick.dds_en",   32'(dds_en), 32'(e.en));
          chk("tick.busy",     32'(busy), 32'(e.bsy));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    carrier_inc = CAR; f0_inc = F0; f1_inc = F1;
    mode_req = 4'd0; mode_req_valid = 1'b0;
    step(3);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    step(1);
    chk("idle.phase", phase_inc, CAR);
    chk("idle.fsk_seed", fsk_phase_inc, F1);

    // Mode requests in IDLE apply on the following cycle.
    mode_req = 4'd3; mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    chk("idle_req.ready_low", 32'(mode_req_ready), 32'd0);
    chk("idle_req.mod_hold", 32'(mod_sel), 32'd0);
    step(1);
    chk("idle_req.mod_applied", 32'(mod_sel), 32'd3);
    chk("idle_req.ready_back", 32'(mode_req_ready), 32'd1);
    mode_req = 4'd0; mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    step(1);
    chk("idle_req.mod_zero", 32'(mod_sel), 32'd0);

    // Start: ARM then RUN; boundaries every 4 cycles.
    start = 1'b1;
    push(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    step(1);
    start = 1'b0;
    chk("arm.busy", 32'(busy), 32'd1);
    chk("arm.dds_en", 32'(dds_en), 32'd0);
    step(1);
    chk("run.dds_en", 32'(dds_en), 32'd1);
    chk("run.lfsr_seed", 32'(lfsr_bit), 32'd1);
    chk("run.fsk_seed", fsk_phase_inc, F1);

    // Mid-symbol request for BPSK, applied at the next boundary.
    step(5);
    mode_req = 4'd2; mode_req_valid = 1'b1;
    push(1'b0, 4'd2, 1'b1, 1'b1, 1'b1);
    step(1);
    mode_req_valid = 1'b0;
    chk("run_req.ready_low", 32'(mode_req_ready), 32'd0);
    chk("run_req.mod_hold", 32'(mod_sel), 32'd0);

    // Request on the terminal-count cycle waits one more symbol.
    step(5);
    mode_req = 4'd1; mode_req_valid = 1'b1;
    push(1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
    push(1'b0, 4'd1, 1'b1, 1'b1, 1'b1);
    step(1);
    mode_req_valid = 1'b0;

    // Stop at counter value 1: one more boundary, then IDLE.
    step(5);
    stop = 1'b1;
    push(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    step(1);
    stop = 1'b0;
    chk("drain.dds_en", 32'(dds_en), 32'd1);
    chk("drain.busy", 32'(busy), 32'd1);
    step(3);
    chk("halt.dds_en", 32'(dds_en), 32'd0);
    chk("halt.busy", 32'(busy), 32'd0);
    step(6);
    chk("halt.still_idle", 32'(dds_en), 32'd0);

    // start and stop together from IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    step(1);
    chk("startstop.busy1", 32'(busy), 32'd0);
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("startstop.busy2", 32'(busy), 32'd0);
    chk("startstop.dds_en", 32'(dds_en), 32'd0);

    // Restart (LFSR reloaded), then reset asynchronously mid-symbol.
    start = 1'b1;
    push(1'b0, 4'd1, 1'b1, 1'b1, 1'b1);
    step(1);
    start = 1'b0;
    step(6);
    chk("restart.dds_en", 32'(dds_en), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    #10 reset_n = 1'b1;
    step(3);
    chk("async_reset.idle", 32'(busy), 32'd0);
    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
